// File: rtl/nn_pkg.sv
// Shared neuron datapath defaults and the signed saturation helper.
// Combinational helpers only; no state, no flow control.
package nn_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int BIAS_W_DEF = 16;
  localparam int SHIFT_DEF  = 6;
  localparam int OUT_W_DEF  = 8;

  // Working width for clamp arithmetic; every datapath width here is far below it.
  localparam int CLAMP_W = 64;

  function automatic logic signed [CLAMP_W-1:0] sat_signed(
    input logic signed [CLAMP_W-1:0] v,
    input int                        width
  );
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/sat_add.sv
// Signed W-bit add clamped to the W-bit range, with an overflow flag.
// Combinational, zero latency; no flow control.
module sat_add
  import nn_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);
  logic signed [W:0]         raw;
  logic signed [CLAMP_W-1:0] wide;
  logic signed [CLAMP_W-1:0] clamped;

  always_comb begin
    raw     = (W+1)'(a) + (W+1)'(b);
    wide    = CLAMP_W'(raw);
    clamped = sat_signed(wide, W);
    sum     = clamped[W-1:0];
    ovf     = (clamped != wide);
  end
endmodule

// File: rtl/neuron_mac.sv
// Two-stage neuron MAC: multiply, saturating accumulate, bias/shift/ReLU/clamp output.
// en in cycle t gives y_valid in cycle t+2; accepts one product per cycle, no backpressure.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int BIAS_W = BIAS_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sel,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [BIAS_W-1:0] bias,
  output logic [OUT_W-1:0]         y,
  output logic                     y_valid,
  output logic                     y_ovf
);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [CLAMP_W-1:0] Y_MAX = (64'sd1 <<< OUT_W) - 64'sd1;

  logic signed [PROD_W-1:0]  p;
  logic                      sel_d;
  logic                      en_d;
  logic signed [BIAS_W-1:0]  bias_d;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   p_ext;
  logic signed [ACC_W-1:0]   acc_next;
  logic                      add_ovf;
  logic                      ovf;
  logic                      ovf_next;
  logic signed [CLAMP_W-1:0] s;
  logic [OUT_W-1:0]          y_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      p      <= '0;
      sel_d  <= 1'b0;
      en_d   <= 1'b0;
      bias_d <= '0;
    end else begin
      p     <= x * w;
      sel_d <= sel;
      en_d  <= en;
      if (en) bias_d <= bias;
    end
  end

  // A group start loads the product onto zero, so its overflow status replaces the sticky flag.
  assign p_ext    = ACC_W'(p);
  assign acc_base = sel_d ? '0 : acc;
  assign ovf_next = add_ovf | (ovf & ~sel_d);

  sat_add #(.W(ACC_W)) u_acc_add (
    .a   (acc_base),
    .b   (p_ext),
    .sum (acc_next),
    .ovf (add_ovf)
  );

  always_comb begin
    s = (CLAMP_W'(acc_next) + CLAMP_W'(bias_d)) >>> SHIFT;
    if (s[CLAMP_W-1])  y_next = '0;
    else if (s > Y_MAX) y_next = '1;
    else                y_next = s[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      ovf     <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
      y_ovf   <= 1'b0;
    end else begin
      acc     <= acc_next;
      ovf     <= ovf_next;
      y_valid <= en_d;
      if (en_d) begin
        y     <= y_next;
        y_ovf <= ovf_next;
      end
    end
  end
endmodule
